// File: rtl/snow64_ext_dat_acc_burst_ctrl.sv
// snow64_ext_dat_acc_burst_ctrl
// Splits one line-wide CPU data access into a burst of BEATS narrow transfers
// on an external req/ack bus. A read is assembled in a shadow line and copied
// to cpu_rd_data only when its last beat completes.
//
// Optional build macro: SNOW64_EXT_DAT_ACC_BURST_CTRL_TIMEOUT_EN
//   defined   - per-beat ack watchdog of TIMEOUT_CYCLES. A timeout aborts the
//               burst and raises cpu_err.
//   undefined - no watchdog. cpu_err is tied low and the burst waits for ack.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; cpu_req at a rising edge starts a burst
// BURST | beat[beat_q] on the bus; bus_req high until bus_ack completes it

module snow64_ext_dat_acc_burst_ctrl #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_WIDTH     = 256,
  parameter int BUS_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_access_type,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [LINE_WIDTH-1:0] cpu_wr_data,
  output logic                  cpu_busy,
  output logic [LINE_WIDTH-1:0] cpu_rd_data,
  output logic                  cpu_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [BUS_WIDTH-1:0]  bus_wr_data,
  input  logic                  bus_ack,
  input  logic [BUS_WIDTH-1:0]  bus_rd_data
);

  localparam int BEATS      = LINE_WIDTH / BUS_WIDTH;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_SHIFT = $clog2(LINE_WIDTH / 8);
  localparam int BUS_SHIFT  = $clog2(BUS_WIDTH / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BEAT_W-1:0]                 beat_q;
  logic                              type_q;
  logic [ADDR_WIDTH-1:0]             base_q;
  logic [BEATS-1:0][BUS_WIDTH-1:0]   line_q;
  logic [BEATS-1:0][BUS_WIDTH-1:0]   shadow_q;
  logic [BEATS-1:0][BUS_WIDTH-1:0]   shadow_merged;
  logic [BEATS-1:0][BUS_WIDTH-1:0]   rd_data_q;
  logic [ADDR_WIDTH-1:0]             beat_off;

  logic in_burst;
  logic accept;
  logic beat_done;
  logic last_beat;
  logic abort;

  assign in_burst  = (state_q == BURST);
  assign accept    = !in_burst && cpu_req;
  assign beat_done = in_burst && bus_ack;
  assign last_beat = (beat_q == LAST_BEAT);

  // Low line-offset bits of the CPU address carry no information here.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cpu_addr[LINE_SHIFT-1:0];

`ifdef SNOW64_EXT_DAT_ACC_BURST_CTRL_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] wait_q;
  logic             err_q;

  // Per-beat watchdog: down-counter reloaded whenever a new beat is issued;
  // terminal count with no ack in the same cycle means TIMEOUT_CYCLES idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else if (accept || (beat_done && !last_beat)) begin
      wait_q <= TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (in_burst && (wait_q != '0)) begin
      wait_q <= wait_q - 1'b1;
    end
  end

  assign abort = in_burst && !bus_ack && (wait_q == '0);

  // Error flag: set by an abort, cleared when the next access is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign cpu_err = err_q;
`else
  // Without the watchdog the timeout length has no meaning.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);

  assign abort   = 1'b0;
  assign cpu_err = 1'b0;
`endif

  // State register; async reset drops an in-flight burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave BURST on the last acked beat or on a watchdog abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if ((beat_done && last_beat) || abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read shadow with the current beat's bus data dropped into its slice.
  always_comb begin
    shadow_merged         = shadow_q;
    shadow_merged[beat_q] = bus_rd_data;
  end

  // Request capture, beat sequencing and read-line assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q    <= '0;
      type_q    <= 1'b0;
      base_q    <= '0;
      line_q    <= '0;
      shadow_q  <= '0;
      rd_data_q <= '0;
    end else if (accept) begin
      beat_q <= '0;
      type_q <= cpu_access_type;
      base_q <= {cpu_addr[ADDR_WIDTH-1:LINE_SHIFT], LINE_SHIFT'(0)};
      line_q <= cpu_wr_data;
    end else if (beat_done) begin
      if (!type_q) begin
        shadow_q <= shadow_merged;
      end
      if (last_beat) begin
        if (!type_q) begin
          rd_data_q <= shadow_merged;
        end
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Base is line aligned, so the beat offset never carries into the base bits.
  assign beat_off = ADDR_WIDTH'(beat_q) << BUS_SHIFT;

  assign cpu_busy    = in_burst;
  assign cpu_rd_data = rd_data_q;
  assign bus_req     = in_burst;
  assign bus_we      = in_burst && type_q;
  assign bus_addr    = in_burst ? (base_q + beat_off) : '0;
  assign bus_wr_data = in_burst ? line_q[beat_q] : '0;

endmodule
